// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer: 32-bit down-counter, 8-bit prescaler, one-shot or periodic
// reload, maskable level interrupt. PRDATA is forced to zero when not selected for OR-combining.
module apb_timer_slave (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_VALUE  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic        en;
    logic        periodic;
    logic        ie;
    logic [7:0]  prescale;
    logic [31:0] load;
    logic [31:0] value;
    logic        intflag;
    logic [7:0]  pcnt;

    logic        wr;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        tick;
    logic        expiry;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{PADDR[31:4], PADDR[1:0]};

    assign wr        = PSEL & PENABLE & PWRITE;
    assign wr_ctrl   = wr && (PADDR[3:2] == ADDR_CTRL);
    assign wr_load   = wr && (PADDR[3:2] == ADDR_LOAD);
    assign wr_status = wr && (PADDR[3:2] == ADDR_STATUS);

    assign tick   = en && (pcnt == prescale);
    assign expiry = tick && (value == 32'd0);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            ie       <= 1'b0;
            prescale <= 8'd0;
            load     <= 32'd0;
            value    <= 32'd0;
            intflag  <= 1'b0;
            pcnt     <= 8'd0;
        end else begin
            // A written EN overrides the one-shot auto-clear on the same edge.
            if (wr_ctrl) begin
                en       <= PWDATA[0];
                periodic <= PWDATA[1];
                ie       <= PWDATA[2];
                prescale <= PWDATA[15:8];
            end else if (expiry && !periodic) begin
                en <= 1'b0;
            end

            if (wr_load) begin
                load <= PWDATA;
            end

            if (wr_load) begin
                value <= PWDATA;
            end else if (tick) begin
                if (value != 32'd0) begin
                    value <= value - 32'd1;
                end else if (periodic) begin
                    value <= load;
                end
            end

            // Expiry takes priority over a software clear landing on the same edge.
            if (expiry) begin
                intflag <= 1'b1;
            end else if (wr_status && PWDATA[0]) begin
                intflag <= 1'b0;
            end

            if (wr_load || (wr_ctrl && !PWDATA[0]) || !en || tick) begin
                pcnt <= 8'd0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (PADDR[3:2])
            ADDR_CTRL:   rd_mux = {16'd0, prescale, 5'd0, ie, periodic, en};
            ADDR_LOAD:   rd_mux = load;
            ADDR_VALUE:  rd_mux = value;
            ADDR_STATUS: rd_mux = {31'd0, intflag};
            default:     rd_mux = 32'd0;
        endcase
    end

    assign PRDATA = (PSEL && !PWRITE) ? rd_mux : 32'd0;
    assign IRQ    = intflag & ie;

endmodule
